// File: rtl/ascii_dec_accumulator_if.sv
// Character-in / binary-result-out bundle for the ASCII decimal accumulator.
// The slave side is the converter; the master side is the byte source plus result sink.
interface ascii_dec_accumulator_if #(
    parameter int OUT_W = 20
);
    logic [7:0]       ascii_in;
    logic             ascii_valid;
    logic             ascii_ready;
    logic [OUT_W-1:0] bin_out;
    logic             bin_valid;
    logic             bin_ready;
    logic             error;
    logic [1:0]       err_code;
    logic [3:0]       digit_count;

    modport master (
        output ascii_in, ascii_valid, bin_ready,
        input  ascii_ready, bin_out, bin_valid, error, err_code, digit_count
    );

    modport slave (
        input  ascii_in, ascii_valid, bin_ready,
        output ascii_ready, bin_out, bin_valid, error, err_code, digit_count
    );
endinterface

// File: rtl/ascii_dec_accumulator.sv
// Streaming ASCII decimal to binary converter: one char per cycle in, one
// registered result per terminated token out, with the first fault code kept.
module ascii_dec_accumulator #(
    parameter int         OUT_W      = 20,
    parameter int         MAX_DIGITS = 6,
    parameter logic [7:0] TERM_CHAR  = 8'h0D
) (
    input  logic                     clk,
    input  logic                     reset,
    ascii_dec_accumulator_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT   = 4'(MAX_DIGITS);
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CHAR  = 2'd1;
    localparam logic [1:0] ERR_OVF   = 2'd2;
    localparam logic [1:0] ERR_EMPTY = 2'd3;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic [OUT_W-1:0] bin_out_q, bin_out_d;
    logic             bin_valid_q, bin_valid_d;
    logic             error_q, error_d;

    logic             ascii_ready;
    logic             char_accept;
    logic             result_xfer;
    logic             is_digit;
    logic             is_term;
    logic [OUT_W+3:0] acc_ext;
    logic [OUT_W+3:0] acc_wide;
    logic             acc_ovf;
    logic             cnt_full;

    assign char_accept = bus.ascii_valid & ascii_ready;
    assign result_xfer = bin_valid_q & bus.bin_ready;
    assign is_digit    = (bus.ascii_in >= 8'h30) && (bus.ascii_in <= 8'h39);
    assign is_term     = (bus.ascii_in == TERM_CHAR);
    assign cnt_full    = (cnt_q >= MAX_CNT);

    // acc*10 + digit as shift-add; the low nibble of '0'..'9' is the digit value.
    assign acc_ext  = {4'b0000, acc_q};
    assign acc_wide = (acc_ext << 3) + (acc_ext << 1) + (OUT_W+4)'(bus.ascii_in[3:0]);
    assign acc_ovf  = |acc_wide[OUT_W+3:OUT_W];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: begin
                if (char_accept) begin
                    if (is_digit) begin
                        if (cnt_full || acc_ovf) begin
                            state_d = ST_DISCARD;
                        end
                    end else if (is_term) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                if (char_accept && is_term) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_xfer) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // FSM output decode: only the result-holding state stalls the byte stream
    always_comb begin
        ascii_ready = (state_q != ST_DONE);
    end

    // Datapath next-state
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        bin_out_d   = bin_out_q;
        bin_valid_d = bin_valid_q;
        error_d     = error_q;
        case (state_q)
            ST_ACCUM: begin
                if (char_accept) begin
                    if (is_digit) begin
                        if (cnt_full || acc_ovf) begin
                            code_d = ERR_OVF;
                        end else begin
                            acc_d = acc_wide[OUT_W-1:0];
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (is_term) begin
                        bin_valid_d = 1'b1;
                        if (cnt_q == 4'd0) begin
                            bin_out_d = '0;
                            error_d   = 1'b1;
                            code_d    = ERR_EMPTY;
                        end else begin
                            bin_out_d = acc_q;
                            error_d   = 1'b0;
                            code_d    = ERR_NONE;
                        end
                    end else begin
                        code_d = ERR_CHAR;
                    end
                end
            end
            ST_DISCARD: begin
                // code_q already holds the first fault; later junk never rewrites it
                if (char_accept && is_term) begin
                    bin_out_d   = '0;
                    error_d     = 1'b1;
                    bin_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (result_xfer) begin
                    bin_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = 4'd0;
                    code_d      = ERR_NONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= 4'd0;
            code_q      <= ERR_NONE;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            error_q     <= error_d;
        end
    end

    assign bus.ascii_ready = ascii_ready;
    assign bus.bin_out     = bin_out_q;
    assign bus.bin_valid   = bin_valid_q;
    assign bus.error       = error_q;
    assign bus.err_code    = code_q;
    assign bus.digit_count = cnt_q;
endmodule

// File: tb/tb_ascii_dec_accumulator.sv
// Drives one shared character stream into a 20-bit and a 16-bit converter and
// compares each result against a token-level reference computed from the input.
module tb_ascii_dec_accumulator;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ascii_in = 8'h00;
    logic       ascii_valid = 1'b0;
    logic       bin_ready = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    ascii_dec_accumulator_if #(.OUT_W(20)) a_if ();
    ascii_dec_accumulator_if #(.OUT_W(16)) b_if ();

    assign a_if.ascii_in    = ascii_in;
    assign a_if.ascii_valid = ascii_valid;
    assign a_if.bin_ready   = bin_ready;
    assign b_if.ascii_in    = ascii_in;
    assign b_if.ascii_valid = ascii_valid;
    assign b_if.bin_ready   = bin_ready;

    ascii_dec_accumulator #(.OUT_W(20), .MAX_DIGITS(6), .TERM_CHAR(8'h0D)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    ascii_dec_accumulator #(.OUT_W(16), .MAX_DIGITS(6), .TERM_CHAR(8'h0D)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Token-level reference: walk the characters before the terminator, keep the first fault.
    function automatic void model(input bq_t q, input int w, output longint val, output int code);
        longint acc;
        int     cnt;
        acc  = 0;
        cnt  = 0;
        code = 0;
        foreach (q[i]) begin
            if (q[i] >= 8'h30 && q[i] <= 8'h39) begin
                if (code == 0) begin
                    if (cnt == 6) begin
                        code = 2;
                    end else begin
                        acc = acc * 10 + longint'(q[i] - 8'h30);
                        if (acc >= (64'd1 << w)) code = 2;
                        else cnt++;
                    end
                end
            end else if (code == 0) begin
                code = 1;
            end
        end
        if (code == 0 && cnt == 0) code = 3;
        val = (code == 0) ? acc : 0;
    endfunction

    task automatic put_char(input logic [7:0] c);
        logic rdy;
        int   n;
        ascii_in    = c;
        ascii_valid = 1'b1;
        n = 0;
        do begin
            rdy = a_if.ascii_ready;
            @(negedge clk);
            n++;
        end while (!rdy && n < 50);
        ascii_valid = 1'b0;
        if (!rdy) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_result(input longint va, input int ca, input longint vb, input int cb);
        chk("a_valid", 64'(a_if.bin_valid), 64'd1);
        chk("a_out",   64'(a_if.bin_out), 64'(va));
        chk("a_err",   64'(a_if.error), 64'(ca != 0));
        chk("a_code",  64'(a_if.err_code), 64'(ca));
        chk("a_rdy_done", 64'(a_if.ascii_ready), 64'd0);
        chk("b_valid", 64'(b_if.bin_valid), 64'd1);
        chk("b_out",   64'(b_if.bin_out), 64'(vb));
        chk("b_err",   64'(b_if.error), 64'(cb != 0));
        chk("b_code",  64'(b_if.err_code), 64'(cb));
    endtask

    task automatic send_token(input bq_t q, input int hold);
        longint va, vb;
        int     ca, cb;
        bq_t    t;
        model(q, 20, va, ca);
        model(q, 16, vb, cb);
        t = q;
        t.push_back(8'h0D);
        foreach (t[i]) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            put_char(t[i]);
        end
        // Terminator was taken at the previous edge: the result must already be up.
        for (int k = 0; k <= hold; k++) begin
            check_result(va, ca, vb, cb);
            if (k < hold) @(negedge clk);
        end
        bin_ready = 1'b1;
        @(negedge clk);
        bin_ready = 1'b0;
        chk("a_valid_clr", 64'(a_if.bin_valid), 64'd0);
        chk("a_rdy_back",  64'(a_if.ascii_ready), 64'd1);
        chk("b_valid_clr", 64'(b_if.bin_valid), 64'd0);
        $display("token len=%0d hold=%0d: w20 exp %0d/code %0d got %0d/%0d, w16 exp %0d/code %0d",
                 q.size(), hold, va, ca, a_if.bin_out, a_if.err_code, vb, cb);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_out"},   64'(a_if.bin_out), 64'd0);
        chk({tag, "_a_valid"}, 64'(a_if.bin_valid), 64'd0);
        chk({tag, "_a_err"},   64'(a_if.error), 64'd0);
        chk({tag, "_a_code"},  64'(a_if.err_code), 64'd0);
        chk({tag, "_a_cnt"},   64'(a_if.digit_count), 64'd0);
        chk({tag, "_b_out"},   64'(b_if.bin_out), 64'd0);
        chk({tag, "_b_valid"}, 64'(b_if.bin_valid), 64'd0);
        chk({tag, "_b_cnt"},   64'(b_if.digit_count), 64'd0);
    endtask

    initial begin
        bq_t   q;
        string directed[$];
        directed = '{"1234", "999999", "1234567", "70000", "65535", "12a4", "",
                     "000001", "0", "1048575", "104857", "65536", "9999999", "1x2y"};

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("rst");
        chk("rst_ready", 64'(a_if.ascii_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        foreach (directed[i]) send_token(s2q(directed[i]), $urandom_range(0, 3));

        // Result held under backpressure, then the following token flows normally.
        send_token(s2q("42"), 5);
        send_token(s2q("7"), 0);

        // Reset in the middle of a token discards the partial value.
        put_char(8'h31);
        put_char(8'h32);
        chk("mid_cnt", 64'(a_if.digit_count), 64'd2);
        reset = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        reset = 1'b0;
        @(negedge clk);
        send_token(s2q("7"), 1);

        for (int n = 0; n < 60; n++) begin
            int len;
            q.delete();
            len = $urandom_range(0, 8);
            for (int j = 0; j < len; j++) begin
                logic [7:0] c;
                if ($urandom_range(0, 99) < 90) begin
                    c = 8'h30 + 8'($urandom_range(0, 9));
                end else begin
                    c = 8'($urandom_range(0, 255));
                    if (c == 8'h0D) c = 8'h78;
                end
                q.push_back(c);
            end
            send_token(q, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
